// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO responder.
//   MMIO_BASE_DEFAULT : default base of the 16-byte I/O window
//   OFF_*             : word offsets (a[3:2]) inside the window
//   ST_*              : bit positions inside the STATUS word
//   status_word()     : packs the STATUS read value
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYC_LO = 2'd2;
  localparam logic [1:0] OFF_CYC_HI = 2'd3;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 4;

  function automatic logic [31:0] status_word(input logic [3:0] cnt, input logic ovf,
                                              input logic empty, input logic full);
    logic [31:0] w;
    w                     = '0;
    w[ST_COUNT_LSB +: 4]  = cnt;
    w[ST_OVF]             = ovf;
    w[ST_EMPTY]           = empty;
    w[ST_FULL]            = full;
    return w;
  endfunction

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Byte FIFO feeding the transmit stream.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and byte
//   pop        : read request (head is consumed at the edge)
//   dout       : head byte (valid while !empty)
//   full, empty, count : occupancy
// A push while full is still accepted when a pop happens in the same cycle;
// the incoming byte lands in the slot the head is leaving.
module tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-side responder for the single-cycle core: word RAM plus an I/O window
// holding a free-running 64-bit cycle counter and a byte TX FIFO.
//   clk, reset          : clock, synchronous active-high reset
//   we, a, wd           : core store strobe, byte address, store data
//   rd                  : combinational load data for address a
//   tx_data, tx_valid   : FIFO head byte / non-empty
//   tx_ready            : downstream accepts the head byte
module dmem_mmio
  import mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram_q [RAM_WORDS];
  logic          ram_hit, mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [1:0]    off;
  logic          push, pop, status_wr;
  logic          full, empty;
  logic [CW-1:0] count;
  logic          ovf_q, ovf_d;
  logic [63:0]   cycle_q, cycle_d;

  assign ram_hit   = (a < 32'(RAM_WORDS * 4));
  assign ram_idx   = a[AW+1:2];
  assign mmio_hit  = (a[31:4] == MMIO_BASE[31:4]);
  assign off       = a[3:2];
  assign push      = we & mmio_hit & (off == OFF_TXDATA);
  assign status_wr = we & mmio_hit & (off == OFF_STATUS);
  assign pop       = tx_valid & tx_ready;
  assign tx_valid  = ~empty;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (wd[7:0]),
    .pop   (pop),
    .dout  (tx_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    ovf_d   = ovf_q;
    cycle_d = cycle_q + 64'd1;
    if (status_wr)                 ovf_d = 1'b0;
    else if (push & full & ~pop)   ovf_d = 1'b1;  // byte dropped
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q   <= 1'b0;
      cycle_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

  // RAM contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we & ram_hit) ram_q[ram_idx] <= wd;
  end

  always_comb begin
    rd = '0;
    if (ram_hit) begin
      rd = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (off)
        OFF_STATUS: rd = status_word(4'(count), ovf_q, empty, full);
        OFF_CYC_LO: rd = cycle_q[31:0];
        OFF_CYC_HI: rd = cycle_q[63:32];
        default:    rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

  localparam int          RAM_WORDS  = 64;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
  localparam logic [31:0] A_TX  = MMIO_BASE + 32'h0;
  localparam logic [31:0] A_ST  = MMIO_BASE + 32'h4;
  localparam logic [31:0] A_CLO = MMIO_BASE + 32'h8;
  localparam logic [31:0] A_CHI = MMIO_BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset, we, tx_valid, tx_ready;
  logic [31:0] a, wd, rd;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  dmem_mmio #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH), .MMIO_BASE(MMIO_BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .a        (a),
    .wd       (wd),
    .rd       (rd),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  // Reference model
  logic [31:0] m_ram    [RAM_WORDS];
  bit          m_ram_ok [RAM_WORDS];
  logic [7:0]  m_q[$];
  bit          m_ovf;
  logic [63:0] m_cyc;

  int          n_assert = 0;
  int          n_fail   = 0;
  bit          chk_en   = 0;
  logic [31:0] last_rd;
  logic [7:0]  last_txd;
  logic        last_txv;

  function automatic bit is_ram(input logic [31:0] addr);
    return addr < 32'(RAM_WORDS * 4);
  endfunction

  function automatic bit is_mmio(input logic [31:0] addr);
    return (addr & 32'hFFFF_FFF0) == MMIO_BASE;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] addr, output bit known);
    int off;
    known = 1;
    if (is_ram(addr)) begin
      known = m_ram_ok[addr / 4];
      return m_ram[addr / 4];
    end
    if (is_mmio(addr)) begin
      off = (addr >> 2) % 4;
      case (off)
        1: return {24'b0, 4'(m_q.size()), 1'b0, m_ovf,
                   1'(m_q.size() == 0), 1'(m_q.size() == FIFO_DEPTH)};
        2: return m_cyc[31:0];
        3: return m_cyc[63:32];
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, check combinational outputs, clock, update model.
  task automatic step(input bit rst, input bit w, input logic [31:0] addr,
                      input logic [31:0] data, input bit rdy);
    bit          known, pop, full, push;
    logic [31:0] e;
    reset = rst; we = w; a = addr; wd = data; tx_ready = rdy;
    #1;
    last_rd  = rd;
    last_txd = tx_data;
    last_txv = tx_valid;
    if (chk_en) begin
      e = exp_rd(addr, known);
      if (known) check("rd", rd, e);
      check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
    end
    @(posedge clk);
    if (w && is_ram(addr)) begin
      m_ram[addr / 4]    = data;
      m_ram_ok[addr / 4] = 1;
    end
    if (rst) begin
      m_q.delete();
      m_ovf  = 0;
      m_cyc  = 0;
      chk_en = 1;
    end else begin
      pop  = (m_q.size() != 0) && rdy;
      full = (m_q.size() == FIFO_DEPTH);
      push = w && is_mmio(addr) && ((addr >> 2) % 4 == 0);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (!full || pop) m_q.push_back(data[7:0]);
        else              m_ovf = 1;
      end
      if (w && is_mmio(addr) && ((addr >> 2) % 4 == 1)) m_ovf = 0;
      m_cyc = m_cyc + 64'd1;
    end
    #1;
  endtask

  initial begin
    logic [31:0] ra, rdat;
    int          sel;
    reset = 1; we = 0; a = 0; wd = 0; tx_ready = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // RAM
    step(0, 1, 32'h10, 32'hDEADBEEF, 0);
    step(0, 0, 32'h10, 0, 0);
    check("ram_0x10", last_rd, 32'hDEADBEEF);
    step(0, 1, 32'h14, 32'h1, 0);
    step(0, 0, 32'h14, 0, 0);
    check("ram_0x14", last_rd, 32'h1);
    step(0, 0, 32'h8000_0000, 0, 0);
    check("unmapped", last_rd, 32'h0);

    // TX path
    step(0, 1, A_TX, 32'h41, 0);
    step(0, 1, A_TX, 32'h42, 0);
    step(0, 0, A_ST, 0, 0);
    check("status_two", last_rd, 32'h20);
    step(0, 0, 0, 0, 1);
    check("tx_first", 32'(last_txd), 32'h41);
    step(0, 0, 0, 0, 1);
    check("tx_second", 32'(last_txd), 32'h42);
    step(0, 0, 0, 0, 1);
    check("tx_drained", 32'(last_txv), 32'h0);

    // Overflow
    for (int i = 0; i < 5; i++) step(0, 1, A_TX, 32'h61 + 32'(i), 0);
    step(0, 0, A_ST, 0, 0);
    check("status_ovf", last_rd, 32'h45);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      check("ovf_drain", 32'(last_txd), 32'h61 + 32'(i));
    end
    step(0, 0, 0, 0, 1);
    check("ovf_empty", 32'(last_txv), 32'h0);
    step(0, 1, A_ST, 32'hFFFF_FFFF, 0);
    step(0, 0, A_ST, 0, 0);
    check("ovf_clear", last_rd, 32'h02);

    // Full with simultaneous pop
    for (int i = 0; i < 4; i++) step(0, 1, A_TX, 32'h71 + 32'(i), 0);
    step(0, 1, A_TX, 32'h55, 1);
    step(0, 0, A_ST, 0, 0);
    check("full_pop_status", last_rd, 32'h41);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      check("full_pop_drain", 32'(last_txd), (i == 3) ? 32'h55 : 32'h72 + 32'(i));
    end

    // Counter
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    step(0, 0, A_CLO, 0, 0);
    check("cyc_ten", last_rd, 32'd10);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycle_q;
    m_cyc = 64'h0000_0000_FFFF_FFFF;
    step(0, 0, A_CLO, 0, 0);
    check("cyc_forced_lo", last_rd, 32'hFFFF_FFFF);
    step(0, 0, A_CHI, 0, 0);
    check("cyc_carry_hi", last_rd, 32'h1);
    step(0, 0, A_CLO, 0, 0);
    check("cyc_carry_lo", last_rd, 32'h1);

    // Reset mid-stream
    step(0, 1, 32'h20, 32'hCAFEF00D, 0);
    for (int i = 0; i < 3; i++) step(0, 1, A_TX, 32'h81 + 32'(i), 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, A_CLO, 0, 0);
    check("rst_cyc", last_rd, 32'h0);
    check("rst_valid", 32'(last_txv), 32'h0);
    step(0, 0, A_ST, 0, 0);
    check("rst_status", last_rd, 32'h02);
    step(0, 0, 32'h20, 0, 0);
    check("rst_ram", last_rd, 32'hCAFEF00D);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      sel  = $urandom_range(0, 9);
      rdat = $urandom;
      if (sel < 4)      ra = 32'($urandom_range(0, RAM_WORDS - 1)) * 4;
      else if (sel < 9) ra = MMIO_BASE + 32'($urandom_range(0, 15));
      else              ra = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, ra, rdat,
           $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
